// File: rtl/imm_src_decode_stage_if.sv
// imm_src_decode_stage_if: fetch-side and downstream handshake bundle for the decode stage.
interface imm_src_decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_imm_src;
  logic            out_illegal;
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm_src, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm_src, out_illegal
  );
endinterface

// File: rtl/imm_src_decode_stage.sv
// imm_src_decode_stage: classifies RV32I immediate format and buffers entries in a 2-entry skid buffer.
package immediate_generator_pkg;
  typedef enum logic [2:0] {
    I_TYPE = 3'd0,
    S_TYPE = 3'd1,
    B_TYPE = 3'd2,
    U_TYPE = 3'd3,
    J_TYPE = 3'd4,
    Z_TYPE = 3'd5
  } ImmSrc_t;
endpackage

module imm_src_decode_stage
  import immediate_generator_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  imm_src_decode_stage_if.slave       bus
);
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    ImmSrc_t         imm_src;
    logic            illegal;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, dec;
  logic [2:0] f3;
  logic acc, con;
  always_comb begin
    f3 = bus.in_instr[14:12];
    dec.instr = bus.in_instr;
    dec.pc = bus.in_pc;
    dec.imm_src = I_TYPE;
    dec.illegal = 1'b0;
    // every legal opcode ends in 2'b11, so compressed/garbage low bits fall to default
    case (bus.in_instr[6:0])
      7'b0000011, 7'b1100111, 7'b0001111, 7'b0110011: dec.imm_src = I_TYPE;
      7'b0010011: dec.imm_src = (f3 == 3'b001 || f3 == 3'b101) ? Z_TYPE : I_TYPE;
      7'b0100011: dec.imm_src = S_TYPE;
      7'b1100011: dec.imm_src = B_TYPE;
      7'b0110111, 7'b0010111: dec.imm_src = U_TYPE;
      7'b1101111: dec.imm_src = J_TYPE;
      7'b1110011: dec.imm_src = f3[2] ? Z_TYPE : I_TYPE;
      default: dec.illegal = 1'b1;
    endcase
  end
  assign acc = bus.in_valid && state_q != FULL;
  assign con = state_q != EMPTY && bus.out_ready;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (acc) begin
        main_d = dec;
        state_d = ONE;
      end
      ONE: if (acc && con) main_d = dec;
      else if (acc) begin
        skid_d = dec;
        state_d = FULL;
      end else if (con) state_d = EMPTY;
      default: if (con) begin
        main_d = skid_q;
        state_d = ONE;
      end
    endcase
    if (flush) state_d = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  assign bus.in_ready = state_q != FULL;
  assign bus.out_valid = state_q != EMPTY;
  assign bus.out_instr = main_q.instr;
  assign bus.out_pc = main_q.pc;
  assign bus.out_imm_src = main_q.imm_src;
  assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_src_decode_stage.sv
// tb_imm_src_decode_stage: directed and randomized checks of the decode stage skid buffer.
module tb_imm_src_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int failures = 0;
  imm_src_decode_stage_if #(.XLEN(32)) bus ();
  imm_src_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_dec(input logic [31:0] i);
    if (i[1:0] != 2'b11) return 4'b1000;
    if (i[6:2] == 5'b00000 || i[6:2] == 5'b11001 || i[6:2] == 5'b00011 || i[6:2] == 5'b01100) return 4'd0;
    if (i[6:2] == 5'b00100) return (i[13:12] == 2'b01) ? 4'd5 : 4'd0;
    if (i[6:2] == 5'b01000) return 4'd1;
    if (i[6:2] == 5'b11000) return 4'd2;
    if (i[6:2] == 5'b01101 || i[6:2] == 5'b00101) return 4'd3;
    if (i[6:2] == 5'b11011) return 4'd4;
    if (i[6:2] == 5'b11100) return i[14] ? 4'd5 : 4'd0;
    return 4'b1000;
  endfunction

  logic [31:0] sweep_i [7] = '{32'h00A00093, 32'h00209113, 32'h00112023, 32'h00208463,
                               32'h123450B7, 32'h008000EF, 32'h0050D073};
  logic [2:0]  sweep_e [7] = '{3'd0, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [6:0]  ops [11] = '{7'h03, 7'h67, 7'h0F, 7'h33, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
  logic [63:0] q [$];
  logic [67:0] held;
  logic [63:0] e;
  logic [31:0] r;
  logic hold_v;
  int sent, got;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 80'(bus.out_valid), 80'd0);
    chk("rst_in_ready", 80'(bus.in_ready), 80'd1);
    chk("rst_fields", {bus.out_instr, bus.out_pc, bus.out_imm_src, bus.out_illegal}, 80'd0);
    rst_n = 1'b1;
    tick;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = sweep_i[k];
      bus.in_pc = 32'(k * 4);
      tick;
      chk("sweep_valid", 80'(bus.out_valid), 80'd1);
      chk("sweep_fields", {bus.out_instr, bus.out_pc, bus.out_imm_src, bus.out_illegal},
          {sweep_i[k], 32'(k * 4), sweep_e[k], 1'b0});
      chk("sweep_in_ready", 80'(bus.in_ready), 80'd1);
    end
    bus.in_valid = 1'b0;
    tick;
    chk("sweep_drain", 80'(bus.out_valid), 80'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0000007F;
    tick;
    chk("illegal_7f", {bus.out_imm_src, bus.out_illegal}, {3'd0, 1'b1});
    bus.in_instr = 32'h00000000;
    tick;
    chk("illegal_00", {bus.out_imm_src, bus.out_illegal}, {3'd0, 1'b1});
    bus.in_valid = 1'b0;
    tick;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00A00093;
    bus.in_pc = 32'h0;
    tick;
    chk("bp_first_ready", 80'(bus.in_ready), 80'd1);
    bus.in_pc = 32'h4;
    tick;
    chk("bp_full_ready", 80'(bus.in_ready), 80'd0);
    bus.in_pc = 32'h8;
    tick;
    chk("bp_stall_pc", 80'(bus.out_pc), 80'h0);
    chk("bp_stall_ready", 80'(bus.in_ready), 80'd0);
    bus.out_ready = 1'b1;
    tick;
    chk("bp_second_pc", {bus.out_valid, bus.out_pc}, {1'b1, 32'h4});
    chk("bp_reready", 80'(bus.in_ready), 80'd1);
    tick;
    chk("bp_third_pc", {bus.out_valid, bus.out_pc}, {1'b1, 32'h8});
    bus.in_valid = 1'b0;
    tick;
    chk("bp_drain", 80'(bus.out_valid), 80'd0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h100;
    tick;
    bus.in_pc = 32'h104;
    tick;
    chk("fl_full", 80'(bus.in_ready), 80'd0);
    flush = 1'b1;
    bus.in_pc = 32'h108;
    tick;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_empty", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});
    tick;
    chk("fl_stays_empty", 80'(bus.out_valid), 80'd0);
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h200;
    tick;
    chk("ar_pre", 80'(bus.out_valid), 80'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_immediate", {bus.out_valid, bus.in_ready, bus.out_instr, bus.out_pc, bus.out_imm_src, bus.out_illegal},
        {1'b0, 1'b1, 68'd0});
    rst_n = 1'b1;
    bus.in_instr = 32'h123450B7;
    bus.in_pc = 32'h300;
    tick;
    chk("ar_after", {bus.out_valid, bus.out_pc, bus.out_imm_src}, {1'b1, 32'h300, 3'd3});
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    chk("ar_drain", 80'(bus.out_valid), 80'd0);
    sent = 0;
    got = 0;
    hold_v = 1'b0;
    held = '0;
    for (int c = 0; c < 70000 && got < 10000; c++) begin
      r = $urandom;
      if ($urandom_range(0, 12) < 11) r[6:0] = ops[$urandom_range(0, 10)];
      bus.in_valid = sent < 10000 && $urandom_range(0, 3) != 0;
      bus.in_instr = r;
      bus.in_pc = 32'(sent * 4);
      bus.out_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (hold_v)
        chk("rnd_stable", {bus.out_valid, bus.out_instr, bus.out_pc, bus.out_imm_src, bus.out_illegal}, {1'b1, held});
      hold_v = bus.out_valid && !bus.out_ready;
      held = {bus.out_instr, bus.out_pc, bus.out_imm_src, bus.out_illegal};
      if (bus.out_valid && bus.out_ready) begin
        e = (q.size() != 0) ? q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        chk("rnd_out", {bus.out_instr, bus.out_pc, bus.out_illegal, bus.out_imm_src},
            {e, ref_dec(e[63:32])});
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({bus.in_instr, bus.in_pc});
        sent++;
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_count", 80'(got), 80'd10000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
